// File: rtl/mult_slice_pkg.sv
// rtl/mult_slice_pkg.sv - mode encodings and per-beat control word for the mult slice
package mult_slice_pkg;

    typedef enum logic [1:0] {
        MODE_MULT = 2'b00,
        MODE_MAC  = 2'b01,
        MODE_DUAL = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef struct packed {
        logic  valid;
        logic  sign;
        mode_e mode;
        logic  acc_clr;
    } beat_ctrl_t;

    localparam int CTRL_WIDTH = $bits(beat_ctrl_t);

endpackage

// File: rtl/mult_pipe_delay.sv
// rtl/mult_pipe_delay.sv - DEPTH x WIDTH shift register with clock enable and sync reset
module mult_pipe_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
                end else if (ce) begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mult_mac_pipe_slice.sv
// rtl/mult_mac_pipe_slice.sv - pipelined signed/unsigned multiplier with MAC and dual half-width modes
module mult_mac_pipe_slice
    import mult_slice_pkg::*;
#(
    parameter int A_WIDTH     = 18,
    parameter int B_WIDTH     = 18,
    parameter int ACC_WIDTH   = 48,
    parameter int PIPE_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 sign,
    input  logic [1:0]           mode,
    input  logic                 acc_clr,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [B_WIDTH-1:0]   B,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] OUT,
    output logic                 acc_ovf
);

    generate
        if ((A_WIDTH % 2) != 0 || A_WIDTH < 4) begin : g_bad_a
            $error("A_WIDTH must be even and >= 4");
        end
        if ((B_WIDTH % 2) != 0 || B_WIDTH < 4) begin : g_bad_b
            $error("B_WIDTH must be even and >= 4");
        end
        if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_acc
            $error("ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
        end
        if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe
            $error("PIPE_STAGES must be in 1..4");
        end
    endgenerate

    localparam int AH = A_WIDTH / 2;
    localparam int BH = B_WIDTH / 2;
    localparam int P  = AH + BH;
    localparam int DW = CTRL_WIDTH + ACC_WIDTH;

    // One guard bit per operand turns sign/unsigned into a single signed multiply.
    logic signed [A_WIDTH:0]   a_x;
    logic signed [B_WIDTH:0]   b_x;
    logic signed [AH:0]        al_x, ah_x;
    logic signed [BH:0]        bl_x, bh_x;
    logic signed [ACC_WIDTH-1:0] full_p;
    logic signed [P-1:0]       pl, ph;

    assign a_x  = {sign & A[A_WIDTH-1], A};
    assign b_x  = {sign & B[B_WIDTH-1], B};
    assign al_x = {sign & A[AH-1], A[AH-1:0]};
    assign ah_x = {sign & A[A_WIDTH-1], A[A_WIDTH-1:AH]};
    assign bl_x = {sign & B[BH-1], B[BH-1:0]};
    assign bh_x = {sign & B[B_WIDTH-1], B[B_WIDTH-1:BH]};

    assign full_p = ACC_WIDTH'(a_x) * ACC_WIDTH'(b_x);
    assign pl     = P'(al_x) * P'(bl_x);
    assign ph     = P'(ah_x) * P'(bh_x);

    beat_ctrl_t            ctrl_in;
    logic [ACC_WIDTH-1:0]  prod_in;

    always_comb begin
        ctrl_in.valid   = in_valid;
        ctrl_in.sign    = sign;
        ctrl_in.mode    = mode_e'(mode);
        ctrl_in.acc_clr = acc_clr;
        prod_in         = full_p;
        if (mode_e'(mode) == MODE_DUAL) prod_in = ACC_WIDTH'({ph, pl});
    end

    logic [DW-1:0]         stage_q;
    beat_ctrl_t            ctrl_q;
    logic [ACC_WIDTH-1:0]  prod_q;

    mult_pipe_delay #(
        .DEPTH (PIPE_STAGES - 1),
        .WIDTH (DW)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .d     ({ctrl_in, prod_in}),
        .q     (stage_q)
    );

    assign {ctrl_q, prod_q} = stage_q;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum_w;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 ovf_now;

    assign sum_w = {1'b0, acc} + {1'b0, prod_q};

    always_comb begin
        acc_next = ctrl_q.acc_clr ? prod_q : sum_w[ACC_WIDTH-1:0];
        ovf_now  = ctrl_q.sign
                 ? ((acc[ACC_WIDTH-1] == prod_q[ACC_WIDTH-1]) &&
                    (sum_w[ACC_WIDTH-1] != acc[ACC_WIDTH-1]))
                 : sum_w[ACC_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            OUT       <= '0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
        end else if (ce) begin
            out_valid <= ctrl_q.valid;
            if (ctrl_q.valid) begin
                if (ctrl_q.mode == MODE_MAC) begin
                    acc     <= acc_next;
                    OUT     <= acc_next;
                    acc_ovf <= ctrl_q.acc_clr ? 1'b0 : (acc_ovf | ovf_now);
                end else begin
                    OUT <= prod_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_mac_pipe_slice.sv
// tb/tb_mult_mac_pipe_slice.sv - directed self-checking bench for mult_mac_pipe_slice
module tb_mult_mac_pipe_slice;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        sign;
    logic [1:0]  mode;
    logic        acc_clr;
    logic [17:0] A;
    logic [17:0] B;

    logic        ov0, of0;
    logic [47:0] q0;
    logic        ov1, of1;
    logic [35:0] q1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_mac_pipe_slice dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .sign(sign),
        .mode(mode), .acc_clr(acc_clr), .A(A), .B(B),
        .out_valid(ov0), .OUT(q0), .acc_ovf(of0)
    );

    mult_mac_pipe_slice #(.ACC_WIDTH(36)) dut36 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .sign(sign),
        .mode(mode), .acc_clr(acc_clr), .A(A), .B(B),
        .out_valid(ov1), .OUT(q1), .acc_ovf(of1)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic [1:0]  m;
        logic        c;
        logic [17:0] a;
        logic [17:0] b;
        logic [47:0] q;
        logic        f;
    } vec_t;

    function automatic vec_t mk(logic v, logic s, logic [1:0] m, logic c,
                                logic [17:0] a, logic [17:0] b, logic [47:0] q, logic f);
        vec_t t;
        t.v = v; t.s = s; t.m = m; t.c = c; t.a = a; t.b = b; t.q = q; t.f = f;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic s, logic [1:0] m, logic c, logic [17:0] a, logic [17:0] b);
        in_valid = v; sign = s; mode = m; acc_clr = c; A = a; B = b;
    endtask

    task automatic test_reset();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", ov0); end
        total++; if (q0 !== 48'h0) begin bad++; $display("FAIL reset OUT got=%h want=0", q0); end
        total++; if (of0 !== 1'b0) begin bad++; $display("FAIL reset acc_ovf got=%b want=0", of0); end
    endtask

    task automatic test_mult_unsigned();
        drive(1, 0, 2'b00, 0, 18'h3FFFF, 18'h3FFFF);
        step();
        drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL umult early_valid got=%b want=0", ov0); end
        step();
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL umult out_valid got=%b want=1", ov0); end
        total++; if (q0 !== 48'h000FFFF80001) begin bad++; $display("FAIL umult OUT got=%h want=000ffff80001", q0); end
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL umult valid_drop got=%b want=0", ov0); end
    endtask

    task automatic test_signed_back_to_back();
        drive(1, 1, 2'b00, 0, 18'h3FFFF, 18'h00002);
        step();
        drive(1, 0, 2'b00, 0, 18'h3FFFF, 18'h00002);
        step();
        drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
        step();
        total++; if (ov0 !== 1'b1 || q0 !== 48'hFFFFFFFFFFFE) begin bad++; $display("FAIL smult OUT got=%h v=%b want=fffffffffffe v=1", q0, ov0); end
        step();
        total++; if (ov0 !== 1'b1 || q0 !== 48'h00000007FFFE) begin bad++; $display("FAIL b2b_umult OUT got=%h v=%b want=00000007fffe v=1", q0, ov0); end
        step();
        total++; if (ov0 !== 1'b0 || q0 !== 48'h00000007FFFE) begin bad++; $display("FAIL hold OUT got=%h v=%b want=00000007fffe v=0", q0, ov0); end
    endtask

    task automatic test_dual();
        drive(1, 0, 2'b10, 0, {9'd3, 9'd5}, {9'd7, 9'd11});
        step();
        drive(1, 1, 2'b10, 0, {9'h1FF, 9'd2}, {9'd3, 9'h1FF});
        step();
        drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
        step();
        total++; if (q0 !== {12'h0, 18'd21, 18'd55}) begin bad++; $display("FAIL dual_u OUT got=%h want=%h", q0, {12'h0, 18'd21, 18'd55}); end
        step();
        total++; if (q0 !== 48'h000FFFF7FFFE) begin bad++; $display("FAIL dual_s OUT got=%h want=000ffff7fffe", q0); end
        step();
    endtask

    task automatic test_mac();
        vec_t tv [10];
        tv[0] = mk(1, 0, 2'b01, 1, 18'd10, 18'd10, 48'd100, 0);
        tv[1] = mk(1, 0, 2'b01, 0, 18'd1,  18'd1,  48'd101, 0);
        tv[2] = mk(1, 0, 2'b00, 0, 18'd2,  18'd2,  48'd4,   0);
        tv[3] = mk(1, 0, 2'b01, 0, 18'd1,  18'd1,  48'd102, 0);
        tv[4] = mk(0, 0, 2'b01, 0, 18'd5,  18'd5,  48'd102, 0);
        tv[5] = mk(1, 0, 2'b01, 0, 18'd1,  18'd1,  48'd103, 0);
        tv[6] = mk(1, 0, 2'b11, 0, 18'd3,  18'd3,  48'd9,   0);
        tv[7] = mk(1, 0, 2'b01, 0, 18'd1,  18'd1,  48'd104, 0);
        tv[8] = mk(1, 1, 2'b01, 1, 18'h3FFFF, 18'd5, 48'hFFFFFFFFFFFB, 0);
        tv[9] = mk(1, 1, 2'b01, 0, 18'd2,  18'd3,  48'd1,   0);
        for (int i = 0; i < 12; i++) begin
            if (i < 10) drive(tv[i].v, tv[i].s, tv[i].m, tv[i].c, tv[i].a, tv[i].b);
            else drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
            step();
            if (i >= 2) begin
                total++;
                if (ov0 !== tv[i-2].v || q0 !== tv[i-2].q || of0 !== tv[i-2].f) begin
                    bad++;
                    $display("FAIL mac[%0d] got v=%b q=%h f=%b want v=%b q=%h f=%b",
                             i-2, ov0, q0, of0, tv[i-2].v, tv[i-2].q, tv[i-2].f);
                end
            end
        end
        step();
    endtask

    task automatic test_overflow();
        vec_t tv [8];
        tv[0] = mk(1, 1, 2'b01, 1, 18'h1FFFF, 18'h1FFFF, 48'h3FFFC0001, 0);
        tv[1] = mk(1, 1, 2'b01, 0, 18'h1FFFF, 18'h1FFFF, 48'h7FFF80002, 0);
        tv[2] = mk(1, 1, 2'b01, 0, 18'h1FFFF, 18'h1FFFF, 48'hBFFF40003, 1);
        tv[3] = mk(1, 0, 2'b00, 0, 18'd2,     18'd3,     48'd6,          1);
        tv[4] = mk(1, 1, 2'b01, 1, 18'd1,     18'd1,     48'd1,          0);
        tv[5] = mk(1, 0, 2'b01, 1, 18'h3FFFF, 18'h3FFFF, 48'hFFFF80001, 0);
        tv[6] = mk(1, 0, 2'b01, 0, 18'h3FFFF, 18'h3FFFF, 48'hFFFF00002, 1);
        tv[7] = mk(1, 0, 2'b01, 1, 18'd1,     18'd1,     48'd1,          0);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(tv[i].v, tv[i].s, tv[i].m, tv[i].c, tv[i].a, tv[i].b);
            else drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
            step();
            if (i >= 2) begin
                total++;
                if (ov1 !== tv[i-2].v || q1 !== tv[i-2].q[35:0] || of1 !== tv[i-2].f) begin
                    bad++;
                    $display("FAIL ovf[%0d] got v=%b q=%h f=%b want v=%b q=%h f=%b",
                             i-2, ov1, q1, of1, tv[i-2].v, tv[i-2].q[35:0], tv[i-2].f);
                end
            end
        end
        step();
    endtask

    task automatic test_stall();
        drive(1, 0, 2'b00, 0, 18'd6, 18'd7);
        step();
        ce = 1'b0;
        drive(1, 0, 2'b00, 0, 18'd9, 18'd9);
        step();
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL stall frozen_valid got=%b want=0", ov0); end
        ce = 1'b1;
        drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL stall cycle4_valid got=%b want=0", ov0); end
        step();
        total++; if (ov0 !== 1'b1 || q0 !== 48'd42) begin bad++; $display("FAIL stall result got=%h v=%b want=42 v=1", q0, ov0); end
        ce = 1'b0;
        step();
        total++; if (ov0 !== 1'b1 || q0 !== 48'd42) begin bad++; $display("FAIL stall hold got=%h v=%b want=42 v=1", q0, ov0); end
        ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL stall ignored_beat[%0d] got=%b want=0", i, ov0); end
        end
    endtask

    task automatic test_reset_in_flight();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1, 1, 2'b01, (i == 0), 18'h1FFFF, 18'h1FFFF);
            else drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
            step();
        end
        total++; if (of1 !== 1'b1) begin bad++; $display("FAIL rst_pre acc_ovf got=%b want=1", of1); end
        drive(1, 0, 2'b01, 0, 18'd7, 18'd7);
        step();
        reset = 1'b1;
        drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin bad++; $display("FAIL rst_flight valid[%0d] got=%b/%b want=0/0", i, ov0, ov1); end
        end
        total++; if (q0 !== 48'h0 || q1 !== 36'h0) begin bad++; $display("FAIL rst_flight OUT got=%h/%h want=0/0", q0, q1); end
        total++; if (of0 !== 1'b0 || of1 !== 1'b0) begin bad++; $display("FAIL rst_flight acc_ovf got=%b/%b want=0/0", of0, of1); end
        drive(1, 0, 2'b01, 0, 18'd1, 18'd1);
        step();
        drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
        step();
        step();
        total++; if (q0 !== 48'd1 || q1 !== 36'd1) begin bad++; $display("FAIL rst_acc OUT got=%h/%h want=1/1", q0, q1); end
    endtask

    initial begin
        reset = 1'b1;
        ce = 1'b1;
        drive(0, 0, 2'b00, 0, 18'h0, 18'h0);
        step();
        step();
        test_reset();
        reset = 1'b0;
        step();
        test_mult_unsigned();
        test_signed_back_to_back();
        test_dual();
        test_mac();
        test_overflow();
        test_stall();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_mac_pipe_slice.md
# mult_mac_pipe_slice

Parametrised, pipelined successor to the fixed 18x18 multiplier slice. It multiplies configurable-width operands in signed or unsigned mode, with three per-beat modes: full multiply, multiply-accumulate, or dual half-width multiply. A valid flag and a clock enable travel with the data. It sits inside the mult logical tile in place of the combinational slice, between the tile's direct interconnect and the routing outputs.

## Interface
- A_WIDTH, 18: operand A width; must be even and ≥ 4.
- B_WIDTH, 18: operand B width; must be even and ≥ 4.
- ACC_WIDTH, 48: output/accumulator width; must be ≥ A_WIDTH + B_WIDTH (elaboration error otherwise).
- PIPE_STAGES, 3: input-to-output latency in cycles; range 1..4 (elaboration error otherwise).
- clk  in  1  single clock; every register is rising-edge.
- reset  in  1  synchronous, active-high.
- ce  in  1  clock enable; 0 freezes every register except reset.
- in_valid  in  1  beat present on A/B/sign/mode/acc_clr.
- sign  in  1  1 = both operands two's complement; 0 = unsigned.
- mode  in  2  00 MULT, 01 MAC, 10 DUAL, 11 reserved (treated as MULT).
- acc_clr  in  1  with a MAC beat: load the accumulator with this product instead of adding.
- A  in  A_WIDTH  multiplicand.
- B  in  B_WIDTH  multiplier.
- out_valid  out  1  result beat on OUT.
- OUT  out  ACC_WIDTH  product, accumulator value, or packed dual products.
- acc_ovf  out  1  sticky accumulator overflow.

## Operation
- sign, mode, acc_clr and valid are captured with their operands and travel down the pipeline. Each beat is self-describing, so mode may change on every beat.
- MULT: full product A*B, sign-extended (sign=1) or zero-extended (sign=0) to ACC_WIDTH.
- DUAL:
  - Low product PL = A[A_WIDTH/2-1:0] * B[B_WIDTH/2-1:0].
  - High product PH = upper halves of A and B.
  - Signedness of each half follows sign.
  - Let P = A_WIDTH/2 + B_WIDTH/2. OUT[P-1:0] = PL and OUT[2P-1:P] = PH, each exactly P bits. Bits above 2P are 0.
- MAC, final stage:
  - acc_clr=1: acc ← extended product and acc_ovf ← 0.
  - acc_clr=0: acc ← acc + extended product, modulo 2^ACC_WIDTH.
  - OUT = new acc value.
  - acc_ovf is set on overflow and stays set until reset or an acc_clr beat. Overflow is signed when sign=1 and unsigned carry-out when sign=0.
- MULT and DUAL beats never modify acc or acc_ovf.
- With out_valid=0, OUT holds its last value.
- Beats with in_valid=0 carry no effect; the accumulator is untouched.

## Timing
- Reset values: out_valid=0, OUT=0, acc=0, acc_ovf=0, all pipeline valids and data 0.
- Latency: a beat accepted at edge N with ce=1 appears with out_valid=1 after PIPE_STAGES more ce=1 edges.
- Throughput: one beat per ce=1 cycle, with no bubbles. Back-to-back MAC beats accumulate every cycle.
- ce=0: no register changes, out_valid and OUT hold, and input beats are ignored (not captured).
- reset while a beat is in flight: all in-flight beats are dropped. No out_valid appears for them, and acc and acc_ovf return to 0.
- reset takes priority over ce.
- The multiplier may be split across stages freely; only the stated latency is contractual.

## Structure
- Package mult_slice_pkg:
  - mode encodings MODE_MULT, MODE_MAC, MODE_DUAL;
  - a per-beat control struct {valid, sign, mode, acc_clr}.
- One sub-module, mult_pipe_delay: a parametrised DEPTH × WIDTH shift register with ce and synchronous reset. It carries the control struct and operands/partial products to the final stage.
- The top holds the multiplier, DUAL packing, accumulator and overflow logic.

## Test plan
- Unsigned MULT with defaults: A=0x3FFFF, B=0x3FFFF, in_valid pulse at cycle 0 -> out_valid exactly at cycle 3, OUT=0x000FFFF80001.
- Signed MULT: A=0x3FFFF (−1), B=0x00002, sign=1 -> OUT=0xFFFFFFFFFFFE. Back-to-back with an unsigned beat of the same operands -> next cycle OUT=0x00000007FFFE.
- DUAL unsigned: A={9'd3,9'd5}, B={9'd7,9'd11} -> OUT[17:0]=55, OUT[35:18]=21, upper bits 0.
- MAC: beat 10*10 with acc_clr, then three 1*1 beats -> OUT 100, 101, 102, 103 on consecutive cycles. An interleaved MULT beat 2*2 shows 4 and leaves the next MAC result at its expected value.
- Overflow with ACC_WIDTH=36, signed: beats 0x1FFFF*0x1FFFF with acc_clr, then two more -> acc_ovf rises with the third result and stays set. A following acc_clr beat clears it.
- Stall and reset:
  - in_valid at cycle 0 with ce=0 in cycles 1–2 -> out_valid at cycle 5.
  - Separate run: reset at cycle 1 with a beat in flight -> no out_valid, OUT=0, acc_ovf=0.
